// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath select encodings and the control word handed to the datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXTSH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int WAIT_CNT_W = 8;

  typedef struct packed {
    logic       memReq;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       pcEn;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control word decoder. Moore outputs apart from the
// ready-qualified fetch strobes and the zero-qualified branch PC enable.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   memReady,
  input  logic   zeroFlag,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memReq  = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALUOP_ADD;
        ctrl.pcSrc   = PCSRC_ALU;
        ctrl.irWrite = memReady;
        ctrl.pcEn    = memReady;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_SEXTSH2;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_SEXT;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memReq = 1'b1;
        ctrl.iorD   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memReq   = 1'b1;
        ctrl.iorD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALUOP_SUB;
        ctrl.pcSrc   = PCSRC_ALUOUT;
        ctrl.pcEn    = zeroFlag;
      end
      S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_SEXT;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regWrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcSrc = PCSRC_JUMP;
        ctrl.pcEn  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, memory wait
// counter with optional timeout, and sticky illegal-opcode / timeout flags.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       zeroFlag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [WAIT_CNT_W:0] TIMEOUT_LIMIT = (WAIT_CNT_W+1)'(MEM_TIMEOUT);

  state_t                stateReg, stateNext, decState;
  logic [WAIT_CNT_W-1:0] waitCntReg, waitCntNext;
  logic                  illegalReg, illegalNext;
  logic                  timeoutReg, timeoutNext;
  logic                  decReady;
  logic                  timeoutHit;
  ctrl_t                 ctrlWord;

  // During reset the decoder sees FETCH with no ready, so selects hold their
  // fetch values and the only remaining enable (memReq) is masked below.
  assign decState = reset ? S_FETCH : stateReg;
  assign decReady = mem_ready & ~reset;

  mips_ctrl_outdec u_outdec (
    .state    (decState),
    .memReady (decReady),
    .zeroFlag (zeroFlag),
    .ctrl     (ctrlWord)
  );

  assign timeoutHit = (MEM_TIMEOUT != 0) && ctrlWord.memReq && !mem_ready &&
                      (({1'b0, waitCntReg} + 9'd1) == TIMEOUT_LIMIT);

  always_comb begin
    stateNext   = stateReg;
    illegalNext = illegalReg;
    timeoutNext = timeoutReg | timeoutHit;
    case (stateReg)
      S_FETCH:   if (mem_ready) stateNext = S_DECODE;
                 else if (timeoutHit) stateNext = S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_RTYPE:     stateNext = S_EXECUTE;
          OP_BEQ:       stateNext = S_BRANCH;
          OP_ADDI:      stateNext = S_ADDIEX;
          OP_J:         stateNext = S_JUMP;
          default: begin
            stateNext   = S_FETCH;
            illegalNext = 1'b1;
          end
        endcase
      end
      S_MEMADR:  stateNext = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) stateNext = S_MEMWB;
                 else if (timeoutHit) stateNext = S_FETCH;
      S_MEMWR:   if (mem_ready || timeoutHit) stateNext = S_FETCH;
      S_EXECUTE: stateNext = S_ALUWB;
      S_BRANCH:  stateNext = S_FETCH;
      S_ADDIEX:  stateNext = S_ADDIWB;
      default:   stateNext = S_FETCH;
    endcase
  end

  // Any state change (or a timeout re-entering FETCH) restarts the count; only
  // memory states ever increment it, and it saturates when timeout is off.
  always_comb begin
    waitCntNext = waitCntReg;
    if (stateNext != stateReg || timeoutHit)
      waitCntNext = '0;
    else if (ctrlWord.memReq && !mem_ready && waitCntReg != '1)
      waitCntNext = waitCntReg + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg   <= S_FETCH;
      waitCntReg <= '0;
      illegalReg <= 1'b0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      illegalReg <= illegalNext;
      timeoutReg <= timeoutNext;
    end
  end

  assign mem_req     = ctrlWord.memReq & ~reset;
  assign IorD        = ctrlWord.iorD;
  assign MemWrite    = ctrlWord.memWrite;
  assign IRWrite     = ctrlWord.irWrite;
  assign RegDst      = ctrlWord.regDst;
  assign MemtoReg    = ctrlWord.memtoReg;
  assign RegWrite    = ctrlWord.regWrite;
  assign ALUSrcA     = ctrlWord.aluSrcA;
  assign ALUSrcB     = ctrlWord.aluSrcB;
  assign ALUOp       = ctrlWord.aluOp;
  assign PCSrc       = ctrlWord.pcSrc;
  assign PCEn        = ctrlWord.pcEn;
  assign illegal_op  = illegalReg;
  assign mem_timeout = timeoutReg;
  assign state       = stateReg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench: an instruction-path model (state sequence per opcode class,
// wait/timeout bookkeeping) predicts state, control word and flags every cycle.
module tb_mips_multicycle_ctrl;

  localparam int TMO = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       zeroFlag;
  logic       mem_ready;
  logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, illegal_op, mem_timeout;
  logic [3:0] state;
  logic [14:0] ctrlVec;

  always #5 clock = ~clock;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .zeroFlag(zeroFlag),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .PCEn(PCEn), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  assign ctrlVec = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Opcode classes: 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 illegal
  logic [5:0] opTab [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  int         pathLen [7] = '{5, 4, 4, 3, 4, 3, 2};

  function automatic int pathState(input int cls, input int p);
    int seq [5];
    case (cls)
      0: seq = '{0, 1, 2, 3, 4};
      1: seq = '{0, 1, 2, 5, 0};
      2: seq = '{0, 1, 6, 7, 0};
      3: seq = '{0, 1, 8, 0, 0};
      4: seq = '{0, 1, 9, 10, 0};
      5: seq = '{0, 1, 11, 0, 0};
      default: seq = '{0, 1, 0, 0, 0};
    endcase
    return seq[p];
  endfunction

  function automatic logic [14:0] cw(input bit req, iord, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, aop, pcs, input bit pcen);
    return {req, iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcen};
  endfunction

  function automatic logic [14:0] expCtrl(input int st, input bit rdy, input bit zf);
    case (st)
      0:  return cw(1, 0, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, rdy);
      1:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
      2:  return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      3:  return cw(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4:  return cw(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      5:  return cw(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      6:  return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      7:  return cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      8:  return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, zf);
      9:  return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      10: return cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      11: return cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1);
      default: return '0;
    endcase
  endfunction

  int cls = 0, pos = 0, waits = 0;
  bit expIll = 0, expTo = 0, newInstr = 1;
  int irwSeen = 0, fetchDone = 0, wrSeen = 0, expWr = 0;
  logic [14:0] rstWord;

  function automatic logic [5:0] illegalOpcode();
    logic [5:0] op;
    op = 6'b111111;
    for (int k = 0; k < 64; k++) begin
      op = 6'($urandom);
      if (op != 6'b100011 && op != 6'b101011 && op != 6'b000000 &&
          op != 6'b000100 && op != 6'b001000 && op != 6'b000010) break;
      op = 6'b111111;
    end
    return op;
  endfunction

  task automatic step();
    int  expSt;
    bit  isMem;
    expSt = pathState(cls, pos);
    check("state", 32'(state), 32'(expSt));
    check("ctrl", 32'(ctrlVec), 32'(expCtrl(expSt, mem_ready, zeroFlag)));
    check("flags", {30'd0, illegal_op, mem_timeout}, {30'd0, expIll, expTo});
    if (IRWrite) irwSeen++;
    if (MemWrite && mem_ready) wrSeen++;
    $display("cyc st=%0d op=%b rdy=%0d ctrl=%h ill=%0d tmo=%0d", state, Opcode,
             mem_ready, ctrlVec, illegal_op, mem_timeout);
    isMem = (expSt == 0) || (expSt == 3) || (expSt == 5);
    if (isMem && !mem_ready) begin
      waits++;
      if (waits == TMO) begin
        expTo = 1;
        waits = 0;
        if (expSt != 0) newInstr = 1;
        pos = 0;
      end
    end else begin
      waits = 0;
      if (expSt == 0) fetchDone++;
      if (expSt == 5) expWr++;
      if (expSt == 1 && cls == 6) expIll = 1;
      pos++;
      if (pos == pathLen[cls]) begin
        pos = 0;
        newInstr = 1;
      end
    end
  endtask

  task automatic runCycle(input int opSel, input bit rdy);
    @(negedge clock);
    reset = 1'b0;
    if (newInstr) begin
      cls = (opSel < 0) ? int'($urandom_range(0, 6)) : opSel;
      Opcode = (cls == 6) ? illegalOpcode() : opTab[cls];
      newInstr = 0;
    end
    mem_ready = rdy;
    zeroFlag = 1'($urandom_range(0, 1));
    #1;
    step();
  endtask

  task automatic resetModel();
    cls = 0; pos = 0; waits = 0;
    expIll = 0; expTo = 0; newInstr = 1;
  endtask

  initial begin
    rstWord   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    reset     = 1'b1;
    Opcode    = 6'b000000;
    zeroFlag  = 1'b0;
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      #1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_ctrl", 32'(ctrlVec), 32'(rstWord));
      check("reset_flags", {30'd0, illegal_op, mem_timeout}, 32'd0);
    end
    resetModel();

    // Fixed-program pass with ready tied high, then a long random pass
    for (int c = 0; c < 7; c++) begin
      do runCycle(c, 1'b1); while (!newInstr);
    end
    repeat (3000) runCycle(-1, $urandom_range(0, 9) < 6);

    // Reset in the middle of a stalled store
    while (!newInstr) runCycle(1, 1'b1);
    repeat (3) runCycle(1, 1'b1);
    repeat (2) runCycle(1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst_mid_state", 32'(state), 32'd5);
    check("rst_mid_ctrl", 32'(ctrlVec), 32'(rstWord));
    resetModel();
    runCycle(1, 1'b1);

    // Store with memory stuck low until the timeout abandons it
    while (!newInstr) runCycle(1, 1'b1);
    repeat (3) runCycle(1, 1'b1);
    repeat (TMO) runCycle(1, 1'b0);
    runCycle(1, 1'b0);
    check("tmo_flag", 32'(mem_timeout), 32'd1);

    // Illegal opcode: decode then straight back to fetch, flag sticks
    while (!newInstr) runCycle(6, 1'b1);
    repeat (2) runCycle(6, 1'b1);
    repeat (4) runCycle(2, 1'b1);
    check("ill_flag", 32'(illegal_op), 32'd1);

    check("irwrite_count", 32'(irwSeen), 32'(fetchDone));
    check("store_count", 32'(wrSeen), 32'(expWr));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
